// File: rtl/i2s_rx.sv
// ============================================================================
// Module   : i2s_rx
// Purpose  : I2S receiver; oversamples sclk/lrclk/sdata and emits L/R words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_rx #(
  parameter int AUDIO_DW    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_valid,
  output logic                locked,
  output logic                frame_err
);

  localparam int            CW      = $clog2(AUDIO_DW + 1);
  localparam logic [CW-1:0] FULL    = CW'(AUDIO_DW);
  localparam logic [0:0]    ST_SYNC = 1'b0;
  localparam logic [0:0]    ST_RUN  = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [0:0]             state_q, state_d;
  logic                   primed_q, primed_d;
  logic                   ws_prev_q, ws_prev_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [AUDIO_DW-1:0]    shreg_q, shreg_d;
  logic                   pend_q, pend_d;
  logic                   pend_ws_q, pend_ws_d;
  logic                   pend_short_q, pend_short_d;
  logic [AUDIO_DW-1:0]    pend_word_q, pend_word_d;
  logic                   pair_q, pair_d;
  logic [AUDIO_DW-1:0]    left_q, left_d;
  logic [AUDIO_DW-1:0]    right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   err_q, err_d;

  logic                   sclk_now, ws_now, sd_now, bit_evt;
  logic [AUDIO_DW-1:0]    word_next;
  logic [CW-1:0]          cnt_next;

  assign sclk_now = sclk_sync_q[SYNC_STAGES-1];
  assign ws_now   = ws_sync_q[SYNC_STAGES-1];
  assign sd_now   = sd_sync_q[SYNC_STAGES-1];
  assign bit_evt  = sclk_now & ~sclk_prev_q;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ws_sync_d    = {ws_sync_q[SYNC_STAGES-2:0], lrclk};
    sd_sync_d    = {sd_sync_q[SYNC_STAGES-2:0], sdata};
    sclk_prev_d  = sclk_now;
    state_d      = state_q;
    primed_d     = primed_q;
    ws_prev_d    = ws_prev_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    pend_d       = 1'b0;
    pend_ws_d    = pend_ws_q;
    pend_short_d = pend_short_q;
    pend_word_d  = pend_word_q;
    pair_d       = pair_q;
    left_d       = left_q;
    right_d      = right_q;
    valid_d      = 1'b0;
    locked_d     = locked_q;
    err_d        = 1'b0;

    // Bits past a full slot are dropped, so long slots keep their top bits.
    word_next = shreg_q;
    cnt_next  = bit_cnt_q;
    if (bit_cnt_q < FULL) begin
      for (int i = 0; i < AUDIO_DW; i++) begin
        if (bit_cnt_q == CW'(AUDIO_DW - 1 - i)) word_next[i] = sd_now;
      end
      cnt_next = bit_cnt_q + CW'(1);
    end

    if (bit_evt) begin
      case (state_q)
        ST_SYNC: begin
          primed_d  = 1'b1;
          ws_prev_d = ws_now;
          if (primed_q && (ws_now != ws_prev_q)) begin
            state_d   = ST_RUN;
            shreg_d   = '0;
            bit_cnt_d = '0;
            pair_d    = 1'b0;
          end
        end
        default: begin
          shreg_d   = word_next;
          bit_cnt_d = cnt_next;
          if (ws_now != ws_prev_q) begin
            pend_d       = 1'b1;
            pend_ws_d    = ws_prev_q;
            pend_word_d  = word_next;
            pend_short_d = (cnt_next < FULL);
            shreg_d      = '0;
            bit_cnt_d    = '0;
            ws_prev_d    = ws_now;
          end
        end
      endcase
    end

    if (pend_q) begin
      err_d = pend_short_q;
      if (!pend_ws_q) begin
        left_d = pend_word_q;
        pair_d = 1'b1;
      end else begin
        right_d = pend_word_q;
        if (pair_q) begin
          valid_d  = 1'b1;
          locked_d = 1'b1;
        end
        pair_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q  <= '0;
      ws_sync_q    <= '0;
      sd_sync_q    <= '0;
      sclk_prev_q  <= 1'b0;
      state_q      <= ST_SYNC;
      primed_q     <= 1'b0;
      ws_prev_q    <= 1'b0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      pend_q       <= 1'b0;
      pend_ws_q    <= 1'b0;
      pend_short_q <= 1'b0;
      pend_word_q  <= '0;
      pair_q       <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      ws_sync_q    <= ws_sync_d;
      sd_sync_q    <= sd_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      state_q      <= state_d;
      primed_q     <= primed_d;
      ws_prev_q    <= ws_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      pend_q       <= pend_d;
      pend_ws_q    <= pend_ws_d;
      pend_short_q <= pend_short_d;
      pend_word_q  <= pend_word_d;
      pair_q       <= pair_d;
      left_q       <= left_d;
      right_q      <= right_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
    end
  end

  assign left_chan    = left_q;
  assign right_chan   = right_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign frame_err    = err_q;

endmodule

`default_nettype wire
